bip_result_tx: RTL and testbench
================================

# bip_result_tx

Run controller and result serializer placed directly downstream of the BIP CPU. On a start pulse it enables the CPU and counts the clock cycles the CPU is enabled. When the CPU reports HALT, it snapshots the program counter, accumulator and cycle count. It then sends the snapshot as a fixed 6-byte frame to the UART transmitter, one byte per byte-level handshake.

## Interface
- NB_DATA, 16, accumulator width; frame format requires 16
- LOG2_N_INSMEM_ADDR, 11, program counter width (≤16, zero-extended to 16 in frame)
- NB_CYCLES, 16, cycle counter width; frame format requires 16
- NB_BYTE, 8, UART byte width
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  global enable; gates CPU run only (see Operation)
- i_start  in  1  run request, single-cycle pulse, sampled in IDLE only
- i_halt  in  1  CPU decoded HALT this cycle (combinational from CPU control)
- i_pc  in  LOG2_N_INSMEM_ADDR  CPU instruction address
- i_acc  in  NB_DATA  CPU accumulator value
- i_tx_done  in  1  UART TX finished current byte, single-cycle pulse
- o_cpu_valid  out  1  CPU enable, drives CPU i_valid
- o_tx_start  out  1  one-cycle request to UART TX to send o_tx_data
- o_tx_data  out  NB_BYTE  byte to transmit
- o_busy  out  1  high in RUN, SEND, WAIT
- o_done  out  1  frame fully sent

## Operation
- FSM states: IDLE, RUN, SEND, WAIT, DONE. Reset → IDLE.
- IDLE: i_start=1 → RUN. Counter cleared to 0 on this transition.
- RUN: o_cpu_valid = i_valid (decoded from the state register, no added register stage). Counter increments only in cycles where o_cpu_valid=1, and saturates at 2^NB_CYCLES-1. i_halt is sampled only when o_cpu_valid=1.
- RUN with i_halt=1 and o_cpu_valid=1:
  - Snapshot {zero-extended i_pc, i_acc, counter+1 (saturating)}.
  - Byte index cleared to 0.
  - Next state SEND.
- Frame order, byte 0 to byte 5: PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
- SEND: o_tx_start=1 for exactly this cycle, then → WAIT. An i_tx_done in SEND is ignored.
- WAIT: on i_tx_done, if index=5 → DONE, else index+1 → SEND.
- o_tx_data = snapshot byte[index] in SEND and WAIT, 0 in all other states. It is stable throughout each byte's SEND+WAIT.
- DONE: o_done=1. Held until i_reset. i_start is ignored.
- i_start is ignored outside IDLE. i_halt is ignored outside RUN.
- i_reset at any state, including mid-frame:
  - Next cycle is IDLE; counter, index and snapshot are cleared.
  - The partial frame is abandoned.
  - No o_tx_start is issued in the cycle after reset.

## Timing
- Reset values: o_cpu_valid=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0.
- i_start at cycle S → o_cpu_valid=1 from S+1 (if i_valid=1).
- HALT sampled at cycle H:
  - o_cpu_valid=1 in H, 0 from H+1. The CPU executes no instruction after HALT.
  - The counter value includes cycle H.
- First o_tx_start at H+1. o_tx_data valid from H+1.
- i_tx_done at cycle D → next o_tx_start at D+1. After the 6th i_tx_done, o_done=1 at D+1.
- Minimum frame time with zero-delay i_tx_done: 12 cycles after H (SEND/WAIT alternate).
- Halt on the first RUN cycle gives cycle count 1.

## Test plan
- Basic run: reset, i_valid=1, i_start pulse. Hold i_halt=1 on the 10th RUN cycle with i_pc=0x005, i_acc=0x1234. UART model returns i_tx_done 3 cycles after each o_tx_start.
  - Required: bytes 0x00, 0x05, 0x12, 0x34, 0x00, 0x0A, each with exactly one o_tx_start pulse.
  - o_cpu_valid high exactly 10 cycles; o_done=1 after the last byte.
- Stall during run: drop i_valid for 4 cycles mid-run, halt after 7 enabled cycles.
  - Required: o_cpu_valid low during the stall; count byte pair 0x00, 0x07.
  - An i_halt pulse asserted while i_valid=0 is ignored.
- Immediate halt: i_halt=1 on the first RUN cycle with i_pc=0x7FF, i_acc=0xFFFF.
  - Required frame: 0x07, 0xFF, 0xFF, 0xFF, 0x00, 0x01.
- Handshake robustness: pulse i_tx_done during SEND and while in IDLE/RUN.
  - Required: ignored, no byte skipped, index advances only on i_tx_done in WAIT.
  - Extra i_start pulses in RUN/WAIT/DONE have no effect.
- Reset mid-frame: assert i_reset after the 3rd o_tx_start.
  - Required: all outputs 0 the next cycle, state IDLE.
  - A new i_start run produces a complete fresh 6-byte frame.
- Saturation: run 70000 enabled cycles before halt.
  - Required: count bytes 0xFF, 0xFF.

Source files
------------

// File: rtl/bip_result_tx.sv
// Run controller for the BIP CPU. It enables the CPU and counts the enabled cycles until HALT,
// then sends {PC, ACC, cycle count} to the UART transmitter as a 6-byte big-endian frame.
module bip_result_tx #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int NB_CYCLES          = 16,
  parameter int NB_BYTE            = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic                          i_start,
  input  logic                          i_halt,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0]            i_acc,
  input  logic                          i_tx_done,
  output logic                          o_cpu_valid,
  output logic                          o_tx_start,
  output logic [NB_BYTE-1:0]            o_tx_data,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int          NB_FRAME  = 48;
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  typedef enum logic [2:0] {IDLE, RUN, SEND, WAIT, DONE} state_t;

  state_t               state;
  logic [NB_CYCLES-1:0] cycle_count;
  logic [NB_CYCLES-1:0] count_next;
  logic [2:0]           byte_index;
  logic [NB_FRAME-1:0]  frame;
  logic [NB_FRAME-1:0]  snapshot;
  logic                 tx_start;
  logic [NB_BYTE-1:0]   tx_data;
  logic                 busy;
  logic                 done;
  logic                 cpu_run;

  function automatic logic [NB_BYTE-1:0] frame_byte(input logic [NB_FRAME-1:0] f,
                                                    input logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = f[47:40];
      3'd1:    frame_byte = f[39:32];
      3'd2:    frame_byte = f[31:24];
      3'd3:    frame_byte = f[23:16];
      3'd4:    frame_byte = f[15:8];
      3'd5:    frame_byte = f[7:0];
      default: frame_byte = '0;
    endcase
  endfunction

  // The CPU enable must follow i_valid in the same cycle, so it is decoded rather than registered.
  assign cpu_run    = (state == RUN) && i_valid;
  assign count_next = (&cycle_count) ? cycle_count : cycle_count + NB_CYCLES'(1);
  assign snapshot   = {16'(i_pc), 16'(i_acc), 16'(count_next)};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      cycle_count <= '0;
      byte_index  <= '0;
      frame       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state       <= RUN;
            cycle_count <= '0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (cpu_run) begin
            cycle_count <= count_next;
            // The HALT cycle itself is counted, hence the snapshot uses count_next.
            if (i_halt) begin
              state      <= SEND;
              frame      <= snapshot;
              byte_index <= '0;
              tx_start   <= 1'b1;
              tx_data    <= frame_byte(snapshot, 3'd0);
            end
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (byte_index == LAST_BYTE) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              tx_data <= '0;
            end else begin
              state      <= SEND;
              byte_index <= byte_index + 3'd1;
              tx_start   <= 1'b1;
              tx_data    <= frame_byte(frame, byte_index + 3'd1);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_cpu_valid = cpu_run;
  assign o_tx_start  = tx_start;
  assign o_tx_data   = tx_data;
  assign o_busy      = busy;
  assign o_done      = done;

endmodule

// File: tb/tb_bip_result_tx.sv
// Randomized self-checking bench for bip_result_tx; expected frames come from the
// halt-time PC/ACC and the number of enabled cycles, computed arithmetically.
module tb_bip_result_tx;

  localparam int NB_DATA            = 16;
  localparam int LOG2_N_INSMEM_ADDR = 11;
  localparam int NB_CYCLES          = 16;
  localparam int NB_BYTE            = 8;

  logic                          clock = 1'b0;
  logic                          i_reset = 1'b0;
  logic                          i_valid = 1'b0;
  logic                          i_start = 1'b0;
  logic                          i_halt = 1'b0;
  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc = '0;
  logic [NB_DATA-1:0]            i_acc = '0;
  logic                          i_tx_done = 1'b0;
  logic                          o_cpu_valid;
  logic                          o_tx_start;
  logic [NB_BYTE-1:0]            o_tx_data;
  logic                          o_busy;
  logic                          o_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_bytes[6];
  logic [7:0] got_bytes[6];
  int         got_count;

  always #5 clock = ~clock;

  bip_result_tx #(
    .NB_DATA(NB_DATA),
    .LOG2_N_INSMEM_ADDR(LOG2_N_INSMEM_ADDR),
    .NB_CYCLES(NB_CYCLES),
    .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clock(clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_start(i_start),
    .i_halt(i_halt),
    .i_pc(i_pc),
    .i_acc(i_acc),
    .i_tx_done(i_tx_done),
    .o_cpu_valid(o_cpu_valid),
    .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  // Reference frame: big-endian PC, ACC, saturated count of enabled cycles.
  task automatic set_expected(input logic [10:0] pc, input logic [15:0] acc, input int n);
    int c;
    c = (n > 65535) ? 65535 : n;
    exp_bytes[0] = 8'(int'(pc) / 256);
    exp_bytes[1] = 8'(int'(pc) % 256);
    exp_bytes[2] = 8'(int'(acc) / 256);
    exp_bytes[3] = 8'(int'(acc) % 256);
    exp_bytes[4] = 8'(c / 256);
    exp_bytes[5] = 8'(c % 256);
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset = 1'b1; i_start = 1'b0; i_halt = 1'b0; i_tx_done = 1'b0; i_valid = 1'b1;
    @(negedge clock);
    i_reset = 1'b0;
  endtask

  task automatic run_cpu(input logic [10:0] pc, input logic [15:0] acc, input int n_enabled,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit noise, output int valid_seen, output int anomalies,
                         output bit timed_out);
    int enabled = 0;
    int stall_left = stall_len;
    int budget = 4 * n_enabled + stall_len + 100;
    bit v;
    bit halted = 1'b0;
    valid_seen = 0; anomalies = 0; timed_out = 1'b0;
    @(negedge clock);
    i_start = 1'b1; i_valid = 1'b1; i_halt = 1'b0; i_tx_done = noise;
    @(negedge clock);
    while (!halted) begin
      if (budget == 0) begin timed_out = 1'b1; break; end
      budget--;
      if (stall_left > 0 && enabled == stall_at) begin
        v = 1'b0;
        stall_left--;
      end else begin
        v = ($urandom_range(99) >= stall_pct);
      end
      i_valid = v;
      i_pc  = 11'($urandom);
      i_acc = 16'($urandom);
      // While disabled, HALT is always raised so that ignoring it is exercised.
      i_halt = !v;
      if (v && enabled + 1 == n_enabled) begin
        i_halt = 1'b1; i_pc = pc; i_acc = acc; halted = 1'b1;
      end
      i_tx_done = noise ? 1'($urandom_range(1)) : 1'b0;
      i_start   = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      if (o_cpu_valid === 1'b1) valid_seen++;
      if (o_cpu_valid !== v || o_busy !== 1'b1 || o_tx_start !== 1'b0 || o_done !== 1'b0)
        anomalies++;
      if (v) enabled++;
      @(negedge clock);
    end
    i_halt = 1'b0; i_start = 1'b0; i_tx_done = 1'b0;
  endtask

  task automatic collect_frame(input int delay, input bit noise, input int max_starts,
                               output int anomalies, output bit timed_out);
    int wait_cnt = -1;
    int budget = 6 * (delay + 2) + 20;
    bit expect_start = 1'b1;
    bit fired;
    bit finished = 1'b0;
    got_count = 0; anomalies = 0; timed_out = 1'b0;
    while (!finished) begin
      if (budget == 0) begin timed_out = 1'b1; break; end
      budget--;
      fired = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin fired = 1'b1; wait_cnt = -1; end
      end
      // With noise, i_tx_done is also pulsed in every cycle the DUT should be in SEND.
      i_tx_done = fired || (noise && expect_start);
      i_valid   = 1'($urandom_range(1));
      i_halt    = 1'($urandom_range(1));
      i_start   = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      if (o_tx_start !== expect_start) anomalies++;
      if (o_tx_start === 1'b1) begin
        if (got_count < 6) got_bytes[got_count] = o_tx_data;
        else anomalies++;
        got_count++;
        wait_cnt = delay;
      end else if (got_count > 0 && got_count <= 6 && o_tx_data !== got_bytes[got_count-1]) begin
        anomalies++;
      end
      if (o_cpu_valid !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) anomalies++;
      expect_start = fired && got_count < 6;
      if ((fired && got_count >= 6) || (max_starts < 6 && got_count == max_starts))
        finished = 1'b1;
      @(negedge clock);
    end
    i_tx_done = 1'b0; i_start = 1'b0; i_halt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({o_cpu_valid, o_tx_start, o_tx_data, o_busy, o_done} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got cpu_valid=%b tx_start=%b data=%02h busy=%b done=%b expected all 0",
               o_cpu_valid, o_tx_start, o_tx_data, o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    do_reset();
    set_expected(11'h005, 16'h1234, 10);
    run_cpu(11'h005, 16'h1234, 10, 0, 0, 0, 1'b0, seen, run_bad, run_to);
    vectors++;
    if (run_to || run_bad != 0 || seen != 10) begin
      miscompares++;
      $display("[TB] FAIL basic_run: got valid_cycles=%0d anomalies=%0d timeout=%0b expected 10/0/0", seen, run_bad, run_to);
    end
    collect_frame(3, 1'b0, 6, col_bad, col_to);
    vectors++;
    if (col_to || col_bad != 0 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL basic_handshake: got starts=%0d anomalies=%0d timeout=%0b expected 6/0/0", got_count, col_bad, col_to);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL basic_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
    #1;
    vectors++;
    if ({o_done, o_busy, o_tx_start, o_cpu_valid, o_tx_data} !== 12'h800) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got done=%b busy=%b tx_start=%b cpu_valid=%b data=%02h expected 1/0/0/0/00",
               o_done, o_busy, o_tx_start, o_cpu_valid, o_tx_data);
    end
  endtask

  task automatic test_stall();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    logic [10:0] pc;
    logic [15:0] acc;
    pc = 11'($urandom); acc = 16'($urandom);
    do_reset();
    set_expected(pc, acc, 7);
    run_cpu(pc, acc, 7, 0, 3, 4, 1'b0, seen, run_bad, run_to);
    vectors++;
    if (run_to || run_bad != 0 || seen != 7) begin
      miscompares++;
      $display("[TB] FAIL stall_run: got valid_cycles=%0d anomalies=%0d timeout=%0b expected 7/0/0", seen, run_bad, run_to);
    end
    collect_frame(1, 1'b0, 6, col_bad, col_to);
    vectors++;
    if (col_to || col_bad != 0 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL stall_handshake: got starts=%0d anomalies=%0d timeout=%0b expected 6/0/0", got_count, col_bad, col_to);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL stall_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_immediate_halt();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    do_reset();
    set_expected(11'h7FF, 16'hFFFF, 1);
    run_cpu(11'h7FF, 16'hFFFF, 1, 0, 0, 0, 1'b0, seen, run_bad, run_to);
    vectors++;
    if (run_to || run_bad != 0 || seen != 1) begin
      miscompares++;
      $display("[TB] FAIL immediate_run: got valid_cycles=%0d anomalies=%0d timeout=%0b expected 1/0/0", seen, run_bad, run_to);
    end
    collect_frame(1, 1'b0, 6, col_bad, col_to);
    vectors++;
    if (col_to || col_bad != 0 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL immediate_handshake: got starts=%0d anomalies=%0d timeout=%0b expected 6/0/0", got_count, col_bad, col_to);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL immediate_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_handshake();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    logic [10:0] pc;
    logic [15:0] acc;
    pc = 11'($urandom); acc = 16'($urandom);
    do_reset();
    i_tx_done = 1'b1;
    #1;
    vectors++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_tx_done: got busy=%b tx_start=%b expected 0/0", o_busy, o_tx_start);
    end
    set_expected(pc, acc, 12);
    run_cpu(pc, acc, 12, 20, 0, 0, 1'b1, seen, run_bad, run_to);
    vectors++;
    if (run_to || run_bad != 0 || seen != 12) begin
      miscompares++;
      $display("[TB] FAIL handshake_run: got valid_cycles=%0d anomalies=%0d timeout=%0b expected 12/0/0", seen, run_bad, run_to);
    end
    collect_frame(2, 1'b1, 6, col_bad, col_to);
    vectors++;
    if (col_to || col_bad != 0 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL handshake_frame: got starts=%0d anomalies=%0d timeout=%0b expected 6/0/0", got_count, col_bad, col_to);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL handshake_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      i_start = 1'(k % 2 == 0); i_tx_done = 1'(k % 2); i_valid = 1'b1; i_halt = 1'b1;
      #1;
      vectors++;
      if ({o_done, o_busy, o_tx_start, o_cpu_valid} !== 4'b1000) begin
        miscompares++;
        $display("[TB] FAIL done_hold%0d: got done=%b busy=%b tx_start=%b cpu_valid=%b expected 1/0/0/0",
                 k, o_done, o_busy, o_tx_start, o_cpu_valid);
      end
      @(negedge clock);
    end
    i_start = 1'b0; i_tx_done = 1'b0; i_halt = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    do_reset();
    set_expected(11'h3A5, 16'hBEEF, 5);
    run_cpu(11'h3A5, 16'hBEEF, 5, 0, 0, 0, 1'b0, seen, run_bad, run_to);
    collect_frame(2, 1'b0, 3, col_bad, col_to);
    vectors++;
    if (run_to || col_to || col_bad != 0 || got_count != 3 || got_bytes[2] !== exp_bytes[2]) begin
      miscompares++;
      $display("[TB] FAIL partial_frame: got starts=%0d byte2=%02h anomalies=%0d expected 3/%02h/0",
               got_count, got_bytes[2], col_bad, exp_bytes[2]);
    end
    i_reset = 1'b1; i_valid = 1'b1;
    @(negedge clock);
    i_reset = 1'b0;
    #1;
    vectors++;
    if ({o_cpu_valid, o_tx_start, o_tx_data, o_busy, o_done} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got cpu_valid=%b tx_start=%b data=%02h busy=%b done=%b expected all 0",
               o_cpu_valid, o_tx_start, o_tx_data, o_busy, o_done);
    end
    set_expected(11'h0C3, 16'h5A5A, 9);
    run_cpu(11'h0C3, 16'h5A5A, 9, 10, 0, 0, 1'b0, seen, run_bad, run_to);
    collect_frame(1, 1'b0, 6, col_bad, col_to);
    vectors++;
    if (run_to || col_to || run_bad != 0 || col_bad != 0 || seen != 9 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL fresh_run: got valid_cycles=%0d starts=%0d anomalies=%0d/%0d expected 9/6/0/0",
               seen, got_count, run_bad, col_bad);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL fresh_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int seen, run_bad, col_bad;
    bit run_to, col_to;
    do_reset();
    set_expected(11'h123, 16'h4567, 70000);
    run_cpu(11'h123, 16'h4567, 70000, 0, 0, 0, 1'b0, seen, run_bad, run_to);
    collect_frame(1, 1'b0, 6, col_bad, col_to);
    vectors++;
    if (run_to || col_to || run_bad != 0 || col_bad != 0 || seen != 70000 || got_count != 6) begin
      miscompares++;
      $display("[TB] FAIL saturation_run: got valid_cycles=%0d starts=%0d anomalies=%0d/%0d expected 70000/6/0/0",
               seen, got_count, run_bad, col_bad);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (got_bytes[k] !== exp_bytes[k]) begin
        miscompares++;
        $display("[TB] FAIL saturation_byte%0d: got %02h expected %02h", k, got_bytes[k], exp_bytes[k]);
      end
    end
  endtask

  task automatic test_random();
    int seen, run_bad, col_bad, n, delay, stall;
    bit run_to, col_to, noise;
    logic [10:0] pc;
    logic [15:0] acc;
    for (int it = 0; it < 6; it++) begin
      pc = 11'($urandom); acc = 16'($urandom);
      n = int'($urandom_range(40, 1));
      stall = int'($urandom_range(40));
      delay = int'($urandom_range(5, 1));
      noise = 1'($urandom_range(1));
      do_reset();
      set_expected(pc, acc, n);
      run_cpu(pc, acc, n, stall, 0, 0, noise, seen, run_bad, run_to);
      collect_frame(delay, noise, 6, col_bad, col_to);
      vectors++;
      if (run_to || col_to || run_bad != 0 || col_bad != 0 || seen != n || got_count != 6) begin
        miscompares++;
        $display("[TB] FAIL random%0d_run: got valid_cycles=%0d starts=%0d anomalies=%0d/%0d expected %0d/6/0/0",
                 it, seen, got_count, run_bad, col_bad, n);
      end
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (got_bytes[k] !== exp_bytes[k]) begin
          miscompares++;
          $display("[TB] FAIL random%0d_byte%0d: got %02h expected %02h", it, k, got_bytes[k], exp_bytes[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_immediate_halt();
    test_handshake();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
